// File: rtl/character_move_ctrl_if.sv
// Signal bundle between the move sequencer and the lane sprite drawer.
// DrawEn/DrawDone handshake: DrawReset pulses low for one cycle to re-arm the drawer, then DrawEn is
// held high until the sequencer samples DrawDone=1 (or times out); DrawDone is only looked at while DrawEn is high.
interface character_move_ctrl_if;
    logic       MoveLeft;
    logic       MoveRight;
    logic       DrawDone;
    logic [3:0] PosOut;
    logic       DrawEn;
    logic       DrawReset;
    logic       Erase;
    logic       Busy;
    logic       Error;
    logic [2:0] dbg_state;

    modport slave (
        input  MoveLeft, MoveRight, DrawDone,
        output PosOut, DrawEn, DrawReset, Erase, Busy, Error, dbg_state
    );

    modport master (
        output MoveLeft, MoveRight, DrawDone,
        input  PosOut, DrawEn, DrawReset, Erase, Busy, Error, dbg_state
    );
endinterface

// File: rtl/character_move_ctrl.sv
// Lane-position sequencer: turns left/right request edges into erase / update / draw passes on the sprite drawer.
module character_move_ctrl #(
    parameter int NUM_POS   = 4,
    parameter int START_POS = 0,
    parameter int TIMEOUT   = 1023
) (
    input  logic                  Clock,
    input  logic                  Reset,
    character_move_ctrl_if.slave  bus
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_INIT       = 3'd0,
        ST_IDLE       = 3'd1,
        ST_ERASE_ARM  = 3'd2,
        ST_ERASE_WAIT = 3'd3,
        ST_UPDATE     = 3'd4,
        ST_DRAW_ARM   = 3'd5,
        ST_DRAW_WAIT  = 3'd6,
        ST_ABORT      = 3'd7
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    pos_q, pos_d;
    logic          dir_q, dir_d;
    logic          pend_valid_q, pend_valid_d;
    logic          pend_dir_q, pend_dir_d;
    logic          left_prev_q, right_prev_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          draw_en_q, draw_en_d;
    logic          draw_reset_q, draw_reset_d;
    logic          erase_q, erase_d;
    logic          busy_q, busy_d;
    logic          error_q, error_d;

    logic rise_l, rise_r, edge_valid, edge_dir;
    logic req_valid, req_dir, req_legal, in_wait, timed_out;

    always_comb begin
        rise_l     = bus.MoveLeft & ~left_prev_q;
        rise_r     = bus.MoveRight & ~right_prev_q;
        // Simultaneous left and right edges cancel out.
        edge_valid = rise_l ^ rise_r;
        edge_dir   = rise_r;
        req_valid  = edge_valid | pend_valid_q;
        req_dir    = edge_valid ? edge_dir : pend_dir_q;
        req_legal  = req_dir ? (pos_q < 4'(NUM_POS - 1)) : (pos_q != 4'd0);
        in_wait    = (state_q == ST_ERASE_WAIT) || (state_q == ST_DRAW_WAIT);
        timed_out  = in_wait && !bus.DrawDone && (cnt_q == CW'(TIMEOUT - 1));

        state_d      = state_q;
        pos_d        = pos_q;
        dir_d        = dir_q;
        pend_valid_d = pend_valid_q;
        pend_dir_d   = pend_dir_q;
        cnt_d        = cnt_q;

        if (state_q != ST_IDLE && edge_valid) begin
            pend_valid_d = 1'b1;
            pend_dir_d   = edge_dir;
        end

        if (state_q == ST_ERASE_ARM || state_q == ST_DRAW_ARM) begin
            cnt_d = '0;
        end else if (in_wait) begin
            cnt_d = cnt_q + CW'(1);
        end

        case (state_q)
            ST_INIT:       state_d = ST_DRAW_ARM;
            ST_IDLE: begin
                // Any request seen here is consumed; illegal ones are simply dropped.
                pend_valid_d = 1'b0;
                if (req_valid && req_legal) begin
                    state_d = ST_ERASE_ARM;
                    dir_d   = req_dir;
                end
            end
            ST_ERASE_ARM:  state_d = ST_ERASE_WAIT;
            ST_ERASE_WAIT: begin
                if (bus.DrawDone) begin
                    state_d = ST_UPDATE;
                    pos_d   = dir_q ? pos_q + 4'd1 : pos_q - 4'd1;
                end else if (timed_out) begin
                    state_d = ST_ABORT;
                end
            end
            ST_UPDATE:     state_d = ST_DRAW_ARM;
            ST_DRAW_ARM:   state_d = ST_DRAW_WAIT;
            ST_DRAW_WAIT: begin
                if (bus.DrawDone) begin
                    state_d = ST_IDLE;
                end else if (timed_out) begin
                    state_d = ST_ABORT;
                end
            end
            ST_ABORT:      state_d = ST_IDLE;
            default:       state_d = ST_INIT;
        endcase

        // Outputs are registered, so they are decoded from the state being entered.
        draw_en_d    = (state_d == ST_ERASE_WAIT) || (state_d == ST_DRAW_WAIT);
        draw_reset_d = !((state_d == ST_INIT) || (state_d == ST_ERASE_ARM) ||
                         (state_d == ST_DRAW_ARM) || (state_d == ST_ABORT));
        erase_d      = (state_d == ST_ERASE_ARM) || (state_d == ST_ERASE_WAIT);
        busy_d       = (state_d != ST_IDLE);
        error_d      = error_q | (state_d == ST_ABORT);
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q      <= ST_INIT;
            pos_q        <= 4'(START_POS);
            dir_q        <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_dir_q   <= 1'b0;
            left_prev_q  <= 1'b0;
            right_prev_q <= 1'b0;
            cnt_q        <= '0;
            draw_en_q    <= 1'b0;
            draw_reset_q <= 1'b0;
            erase_q      <= 1'b0;
            busy_q       <= 1'b1;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pos_q        <= pos_d;
            dir_q        <= dir_d;
            pend_valid_q <= pend_valid_d;
            pend_dir_q   <= pend_dir_d;
            left_prev_q  <= bus.MoveLeft;
            right_prev_q <= bus.MoveRight;
            cnt_q        <= cnt_d;
            draw_en_q    <= draw_en_d;
            draw_reset_q <= draw_reset_d;
            erase_q      <= erase_d;
            busy_q       <= busy_d;
            error_q      <= error_d;
        end
    end

    assign bus.PosOut    = pos_q;
    assign bus.DrawEn    = draw_en_q;
    assign bus.DrawReset = draw_reset_q;
    assign bus.Erase     = erase_q;
    assign bus.Busy      = busy_q;
    assign bus.Error     = error_q;
    assign bus.dbg_state = state_q;
endmodule
